// File: rtl/muldiv_sequencer_pkg.sv
// Shared constants for the RV32M sequencer: funct3/funct7 codes, FSM states, default width.
package muldiv_sequencer_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [6:0] FUNCT7_M = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1).
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic                mode,
   input  logic [2*XLEN-1:0]   acc,
   input  logic [XLEN-1:0]     operand,
   output logic [2*XLEN-1:0]   acc_next
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   always_comb begin
      // multiply: acc = {partial high, remaining multiplier bits}
      sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
      // divide: acc = {partial remainder, dividend bits becoming quotient}
      rem_sh = acc[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, operand};
      if (!mode)
         acc_next = {sum, acc[XLEN-1:1]};
      else if (!diff[XLEN])
         acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M multiply/divide controller; stalls the pipe until the result is ready.
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int CNT_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   state_e            state;
   logic [CNT_W-1:0]  cnt;
   logic [2:0]        op;
   logic              neg_q, rneg_q;
   logic [2*XLEN-1:0] acc, acc_nx;
   logic [XLEN-1:0]   opnd, res_q, out_q;

   muldiv_step #(.XLEN(XLEN)) u_step (
      .mode     (op[2]),
      .acc      (acc),
      .operand  (opnd),
      .acc_next (acc_nx)
   );

   logic            sgn_a, sgn_b, accept, div_zero, div_ovf;
   logic [XLEN-1:0] abs_a, abs_b, special;

   always_comb begin
      sgn_a = 1'b0;
      sgn_b = 1'b0;
      case (funct3_i)
         F3_MULH, F3_DIV, F3_REM: begin
            sgn_a = rs1_i[XLEN-1];
            sgn_b = rs2_i[XLEN-1];
         end
         F3_MULHSU: sgn_a = rs1_i[XLEN-1];
         default: ;
      endcase
      abs_a    = sgn_a ? -rs1_i : rs1_i;
      abs_b    = sgn_b ? -rs2_i : rs2_i;
      div_zero = funct3_i[2] && (rs2_i == '0);
      div_ovf  = (funct3_i == F3_DIV || funct3_i == F3_REM) &&
                 (rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_i == '1);
      if (div_zero)
         special = funct3_i[1] ? rs1_i : '1;
      else
         special = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      accept   = (state == ST_IDLE) && start_i && !kill_i;
   end

   // Sign correction applied to the final iteration's output
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo, rem, fin;

   always_comb begin
      prod = neg_q  ? -acc_nx : acc_nx;
      quo  = neg_q  ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
      rem  = rneg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
      case (op)
         F3_MUL:                      fin = prod[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: fin = prod[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:             fin = quo;
         default:                     fin = rem;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         op     <= '0;
         neg_q  <= 1'b0;
         rneg_q <= 1'b0;
         acc    <= '0;
         opnd   <= '0;
         res_q  <= '0;
         out_q  <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op     <= funct3_i;
               neg_q  <= sgn_a ^ sgn_b;
               rneg_q <= sgn_a;
               acc    <= {{XLEN{1'b0}}, abs_a};
               opnd   <= abs_b;
               cnt    <= '0;
               if (div_zero || div_ovf) begin
                  res_q <= special;
                  state <= ST_DONE;
               end else begin
                  state <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (kill_i) begin
                  state <= ST_IDLE;
               end else begin
                  acc <= acc_nx;
                  cnt <= cnt + 1'b1;
                  if (cnt == CNT_W'(XLEN-1)) begin
                     res_q <= fin;
                     state <= ST_DONE;
                  end
               end
            end
            ST_DONE: begin
               if (!kill_i) out_q <= res_q;
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // A kill in the DONE cycle suppresses the pulse and keeps the old result visible
   assign done_o   = (state == ST_DONE) && !kill_i;
   assign result_o = done_o ? res_q : out_q;
   assign busy_o   = (state != ST_IDLE);
   assign stall_o  = ((state == ST_IDLE) && start_i && !kill_i) || (state == ST_BUSY);

endmodule
